mem_access_unit: RTL

Load/store initiator that drives the word-organised data cache on behalf of the CPU's memory stage. Accepts one byte/halfword/word load or store at a time over a valid/ready request channel, generates the cache's read and write strobes, performs read-modify-write for sub-word stores, and returns aligned, extended load data over a valid/ready response channel. Sits between the execute/memory pipeline stage and the data cache.

---
 rtl/mem_access_pkg.sv | 28 ++
 rtl/lane_align.sv | 43 ++++
 rtl/mem_access_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings, FSM states and helpers for mem_access_unit
package mem_access_pkg;

   localparam int DEFAULT_ADDR_W = 10;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_RD,
      S_LD_CAP,
      S_ST_WR,
      S_RMW_RD,
      S_RMW_WR,
      S_RESP
   } state_e;

   // Requests that must be rejected without touching the cache.
   function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] lane);
      return (size == SZ_ILL) ||
             (size == SZ_HALF && lane[0]) ||
             (size == SZ_WORD && lane != 2'b00);
   endfunction

endpackage

// File: rtl/lane_align.sv
// rtl/lane_align.sv - combinational lane extract/extend for loads and lane merge for sub-word stores
module lane_align
   import mem_access_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        signed_ext,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [31:0] shifted;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      shifted  = rdata >> {lane, 3'b000};
      byte_sel = shifted[7:0];
      half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

      case (size)
         SZ_BYTE: load_data = {{24{signed_ext & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_data = {{16{signed_ext & half_sel[15]}}, half_sel};
         default: load_data = rdata;
      endcase

      merge_data = rdata;
      if (size == SZ_BYTE) begin
         case (lane)
            2'd0:    merge_data[7:0]   = wdata[7:0];
            2'd1:    merge_data[15:8]  = wdata[7:0];
            2'd2:    merge_data[23:16] = wdata[7:0];
            default: merge_data[31:24] = wdata[7:0];
         endcase
      end else if (size == SZ_HALF) begin
         if (lane[1]) merge_data[31:16] = wdata[15:0];
         else         merge_data[15:0]  = wdata[15:0];
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator driving a word-organised data cache
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [31:0]       mem_rdata
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [31:0] load_data;
   logic [31:0] merge_data;

   lane_align u_lane_align (
      .rdata      (mem_rdata),
      .lane       (addr_q[1:0]),
      .size       (size_q),
      .signed_ext (signed_q),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      size_d   = size_q;
      signed_d = signed_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               size_d   = req_size;
               signed_d = req_signed;
               we_d     = req_we;
               wdata_d  = req_wdata;
               rdata_d  = '0;
               err_d    = 1'b0;
               if (is_bad_req(req_size, req_addr[1:0])) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else if (!req_we) begin
                  state_d = S_LD_RD;
               end else if (req_size == SZ_WORD) begin
                  state_d = S_ST_WR;
               end else begin
                  state_d = S_RMW_RD;
               end
            end
         end
         S_LD_RD:  state_d = S_LD_CAP;
         S_LD_CAP: begin
            rdata_d = load_data;
            state_d = S_RESP;
         end
         S_ST_WR:  state_d = S_RESP;
         S_RMW_RD: state_d = S_RMW_WR;
         S_RMW_WR: state_d = S_RESP;
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         size_q   <= SZ_BYTE;
         signed_q <= 1'b0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // Cache strobes decode straight from state so a write in flight at reset still lands.
   always_comb begin
      req_ready  = (state_q == S_IDLE);
      resp_valid = (state_q == S_RESP);
      resp_rdata = rdata_q;
      resp_err   = err_q;
      mem_read   = (state_q == S_LD_RD) || (state_q == S_RMW_RD);
      mem_write  = (state_q == S_ST_WR) || (state_q == S_RMW_WR);
      mem_addr   = (state_q == S_IDLE) ? '0 : addr_q[ADDR_W-1:2];
      mem_data   = (state_q == S_RMW_WR) ? merge_data : wdata_q;
   end

endmodule
